// File: rtl/park_pkg.sv
// park_pkg
//   Shared definitions for the parking controller: slot geometry, the
//   controller state type and a helper that counts free slots in an
//   occupancy vector.
package park_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;
  localparam int COUNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Number of clear bits in an occupancy vector (0..NUM_SLOTS).
  function automatic logic [COUNT_W-1:0] count_free(input logic [NUM_SLOTS-1:0] occ);
    logic [COUNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occ[i]) cnt = cnt + 1'b1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/parking_controller_slot_finder.sv
// slot_finder
//   Combinational priority encoder returning the lowest-index free slot.
//   Ports:
//     i_occupancy  in   NUM_SLOTS  one bit per slot, 1 = occupied
//     o_slot       out  SLOT_W     index of the lowest clear bit (0 when none)
//     o_any_free   out  1          at least one slot is free
module slot_finder
  import park_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] i_occupancy,
  output logic [SLOT_W-1:0]    o_slot,
  output logic                 o_any_free
);

  // Scan from the top down so the last match written is the lowest index.
  always_comb begin
    o_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!i_occupancy[i]) o_slot = i[SLOT_W-1:0];
    end
  end

  assign o_any_free = ~&i_occupancy;

endmodule

// File: rtl/parking_controller.sv
// parking_controller
//   Eight-slot parking allocator. An entry request grabs the lowest free
//   slot and issues an encrypted token (slot XOR pattern); an exit request
//   decrypts the presented token and frees that slot if it is occupied.
//   Each request runs IDLE -> ENTRY/EXIT -> RESP -> IDLE, and the result
//   pulse is high for exactly the RESP cycle.
//   Optional feature macro: PARK_STATS_EN adds o_reject_count.
//   Ports:
//     i_clk, i_rst        clock, synchronous active-high reset
//     i_enter_req         entry request (IDLE only)
//     i_exit_req          exit request (IDLE only), wins over entry
//     i_exit_token[2:0]   token captured together with i_exit_req
//     i_pattern_load      load i_pattern_in (IDLE, no other request)
//     i_pattern_in[2:0]   new cipher pattern
//     o_busy              controller is not in IDLE
//     o_token_out[2:0]    token of the last successful entry
//     o_entry_ok/_err     entry result pulses
//     o_exit_ok/_err      exit result pulses
//     o_full              all slots occupied (registered)
//     o_free_count[3:0]   free slots, 0..8 (registered)
//     o_reject_count[7:0] saturating error-pulse count (PARK_STATS_EN only)
module parking_controller
  import park_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enter_req,
  input  logic               i_exit_req,
  input  logic [SLOT_W-1:0]  i_exit_token,
  input  logic               i_pattern_load,
  input  logic [SLOT_W-1:0]  i_pattern_in,
  output logic               o_busy,
  output logic [SLOT_W-1:0]  o_token_out,
  output logic               o_entry_ok,
  output logic               o_entry_err,
  output logic               o_exit_ok,
  output logic               o_exit_err,
  output logic               o_full,
  output logic [COUNT_W-1:0] o_free_count
`ifdef PARK_STATS_EN
  ,
  output logic [7:0]         o_reject_count
`endif
);

  state_t               r_state;
  logic [NUM_SLOTS-1:0] r_occ;
  logic [SLOT_W-1:0]    r_pattern;
  logic [SLOT_W-1:0]    r_exit_token;
  logic [SLOT_W-1:0]    r_token_out;
  logic                 r_entry_ok;
  logic                 r_entry_err;
  logic                 r_exit_ok;
  logic                 r_exit_err;
  logic                 r_full;
  logic [COUNT_W-1:0]   r_free_count;

  state_t               w_state_next;
  logic [NUM_SLOTS-1:0] w_occ_next;
  logic [SLOT_W-1:0]    w_pattern_next;
  logic [SLOT_W-1:0]    w_exit_token_next;
  logic [SLOT_W-1:0]    w_token_out_next;
  logic                 w_entry_ok_next;
  logic                 w_entry_err_next;
  logic                 w_exit_ok_next;
  logic                 w_exit_err_next;
  logic [SLOT_W-1:0]    w_free_slot;
  logic                 w_any_free;
  logic [SLOT_W-1:0]    w_exit_slot;

  slot_finder u_slot_finder (
    .i_occupancy (r_occ),
    .o_slot      (w_free_slot),
    .o_any_free  (w_any_free)
  );

  assign w_exit_slot = r_exit_token ^ r_pattern;

  // Next-state and datapath updates. Result pulses are registered on the
  // ENTRY/EXIT -> RESP edge and default back to 0, so they live only in RESP.
  always_comb begin
    w_state_next      = r_state;
    w_occ_next        = r_occ;
    w_pattern_next    = r_pattern;
    w_exit_token_next = r_exit_token;
    w_token_out_next  = r_token_out;
    w_entry_ok_next   = 1'b0;
    w_entry_err_next  = 1'b0;
    w_exit_ok_next    = 1'b0;
    w_exit_err_next   = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_exit_req) begin
          w_state_next      = EXIT;
          w_exit_token_next = i_exit_token;
        end else if (i_enter_req) begin
          w_state_next = ENTRY;
        end else if (i_pattern_load) begin
          w_pattern_next = i_pattern_in;
        end
      end
      ENTRY: begin
        w_state_next = RESP;
        if (w_any_free) begin
          w_occ_next[w_free_slot] = 1'b1;
          w_token_out_next        = w_free_slot ^ r_pattern;
          w_entry_ok_next         = 1'b1;
        end else begin
          w_entry_err_next = 1'b1;
        end
      end
      EXIT: begin
        w_state_next = RESP;
        if (r_occ[w_exit_slot]) begin
          w_occ_next[w_exit_slot] = 1'b0;
          w_exit_ok_next          = 1'b1;
        end else begin
          w_exit_err_next = 1'b1;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers. full/free_count are derived from the
  // registered occupancy, so they trail an occupancy change by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_occ        <= '0;
      r_pattern    <= '0;
      r_exit_token <= '0;
      r_token_out  <= '0;
      r_entry_ok   <= 1'b0;
      r_entry_err  <= 1'b0;
      r_exit_ok    <= 1'b0;
      r_exit_err   <= 1'b0;
      r_full       <= 1'b0;
      r_free_count <= COUNT_W'(NUM_SLOTS);
    end else begin
      r_state      <= w_state_next;
      r_occ        <= w_occ_next;
      r_pattern    <= w_pattern_next;
      r_exit_token <= w_exit_token_next;
      r_token_out  <= w_token_out_next;
      r_entry_ok   <= w_entry_ok_next;
      r_entry_err  <= w_entry_err_next;
      r_exit_ok    <= w_exit_ok_next;
      r_exit_err   <= w_exit_err_next;
      r_full       <= &r_occ;
      r_free_count <= count_free(r_occ);
    end
  end

`ifdef PARK_STATS_EN
  logic [7:0] r_reject_count;

  // Counts error pulses while they are visible, saturating at 255.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reject_count <= '0;
    end else if ((r_entry_err || r_exit_err) && (r_reject_count != 8'hFF)) begin
      r_reject_count <= r_reject_count + 8'd1;
    end
  end

  assign o_reject_count = r_reject_count;
`endif

  assign o_busy       = (r_state != IDLE);
  assign o_token_out  = r_token_out;
  assign o_entry_ok   = r_entry_ok;
  assign o_entry_err  = r_entry_err;
  assign o_exit_ok    = r_exit_ok;
  assign o_exit_err   = r_exit_err;
  assign o_full       = r_full;
  assign o_free_count = r_free_count;

endmodule

// File: tb/tb_parking_controller.sv
// tb_parking_controller
//   Self-checking bench for parking_controller: a directed vector table,
//   hand-written multi-cycle corner sequences (busy-ignore, reset during
//   ENTRY) and a randomized phase checked against a transaction-level model.
//   Honours PARK_STATS_EN for the optional reject counter.
module tb_parking_controller;

  logic       i_clk;
  logic       i_rst;
  logic       i_enter_req;
  logic       i_exit_req;
  logic [2:0] i_exit_token;
  logic       i_pattern_load;
  logic [2:0] i_pattern_in;
  logic       o_busy;
  logic [2:0] o_token_out;
  logic       o_entry_ok;
  logic       o_entry_err;
  logic       o_exit_ok;
  logic       o_exit_err;
  logic       o_full;
  logic [3:0] o_free_count;
`ifdef PARK_STATS_EN
  logic [7:0] o_reject_count;
`endif

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model
  bit         mOcc[8];
  logic [2:0] mPattern;
  logic [2:0] mTok;
  int         mRejects;

  parking_controller dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_enter_req    (i_enter_req),
    .i_exit_req     (i_exit_req),
    .i_exit_token   (i_exit_token),
    .i_pattern_load (i_pattern_load),
    .i_pattern_in   (i_pattern_in),
    .o_busy         (o_busy),
    .o_token_out    (o_token_out),
    .o_entry_ok     (o_entry_ok),
    .o_entry_err    (o_entry_err),
    .o_exit_ok      (o_exit_ok),
    .o_exit_err     (o_exit_err),
    .o_full         (o_full),
    .o_free_count   (o_free_count)
`ifdef PARK_STATS_EN
    ,
    .o_reject_count (o_reject_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    bit         enter;
    bit         exitR;
    logic [2:0] token;
    bit         load;
    logic [2:0] pat;
    bit         eok;
    bit         eerr;
    bit         xok;
    bit         xerr;
    logic [2:0] tok;
    logic [3:0] free;
    bit         full;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {o_entry_ok, o_entry_err, o_exit_ok, o_exit_err};
  endfunction

  // Called at a negedge; returns at a negedge with the controller back in IDLE.
  task automatic applyStimulus(input string tag, input bit enter, input bit exitR,
                               input logic [2:0] token, input bit load, input logic [2:0] pat,
                               input bit eok, input bit eerr, input bit xok, input bit xerr,
                               input logic [2:0] tok, input logic [3:0] free, input bit full);
    i_enter_req    = enter;
    i_exit_req     = exitR;
    i_exit_token   = token;
    i_pattern_load = load;
    i_pattern_in   = pat;
    @(posedge i_clk);
    @(negedge i_clk);
    i_enter_req    = 1'b0;
    i_exit_req     = 1'b0;
    i_exit_token   = 3'b000;
    i_pattern_load = 1'b0;
    if (enter || exitR) begin
      checkOutput({tag, " busy in ENTRY/EXIT"}, 8'(o_busy), 8'd1);
      checkOutput({tag, " pulses before RESP"}, 8'(pulses()), 8'd0);
      @(negedge i_clk);
      checkOutput({tag, " pulses in RESP"}, 8'(pulses()), 8'({eok, eerr, xok, xerr}));
      checkOutput({tag, " busy in RESP"}, 8'(o_busy), 8'd1);
      checkOutput({tag, " token_out"}, 8'(o_token_out), 8'(tok));
      @(negedge i_clk);
      checkOutput({tag, " pulses after RESP"}, 8'(pulses()), 8'd0);
    end
    checkOutput({tag, " busy idle"}, 8'(o_busy), 8'd0);
    checkOutput({tag, " token held"}, 8'(o_token_out), 8'(tok));
    checkOutput({tag, " free_count"}, 8'(o_free_count), 8'(free));
    checkOutput({tag, " full"}, 8'(o_full), 8'(full));
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    checkOutput("reset busy", 8'(o_busy), 8'd0);
    checkOutput("reset pulses", 8'(pulses()), 8'd0);
    checkOutput("reset token_out", 8'(o_token_out), 8'd0);
    checkOutput("reset free_count", 8'(o_free_count), 8'd8);
    checkOutput("reset full", 8'(o_full), 8'd0);
`ifdef PARK_STATS_EN
    checkOutput("reset reject_count", o_reject_count, 8'd0);
`endif
    i_rst = 1'b0;
    for (int s = 0; s < 8; s++) mOcc[s] = 1'b0;
    mPattern = 3'b000;
    mTok     = 3'b000;
    mRejects = 0;
  endtask

  // Applies one random transaction, predicting the outcome from the rules.
  task automatic randomTxn(input int idx);
    bit         enter, exitR, load;
    logic [2:0] token, pat, slot;
    bit         eok, eerr, xok, xerr, found;
    int         freeCnt;
    enter = ($urandom_range(0, 99) < 50);
    exitR = ($urandom_range(0, 99) < 40);
    load  = ($urandom_range(0, 9) == 0);
    pat   = 3'($urandom_range(0, 7));
    token = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 9) < 7) token = token ^ mPattern;
    eok = 0; eerr = 0; xok = 0; xerr = 0;
    if (exitR) begin
      slot = token ^ mPattern;
      if (mOcc[slot]) begin
        mOcc[slot] = 1'b0;
        xok = 1;
      end else begin
        xerr = 1;
        mRejects++;
      end
    end else if (enter) begin
      found = 0;
      for (int s = 0; s < 8; s++) begin
        if (!found && !mOcc[s]) begin
          found   = 1;
          mOcc[s] = 1'b1;
          mTok    = 3'(s) ^ mPattern;
        end
      end
      if (found) eok = 1;
      else begin
        eerr = 1;
        mRejects++;
      end
    end else if (load) begin
      mPattern = pat;
    end
    freeCnt = 0;
    for (int s = 0; s < 8; s++) if (!mOcc[s]) freeCnt++;
    applyStimulus($sformatf("rand%0d", idx), enter, exitR, token, load, pat,
                  eok, eerr, xok, xerr, mTok, 4'(freeCnt), (freeCnt == 0));
`ifdef PARK_STATS_EN
    checkOutput($sformatf("rand%0d reject_count", idx), o_reject_count,
                8'((mRejects > 255) ? 255 : mRejects));
`endif
  endtask

  initial begin
    // enter exit token load pat   eok eerr xok xerr tok    free  full
    vecs[0]  = '{0, 0, 3'b000, 1, 3'b101, 0, 0, 0, 0, 3'b000, 4'd8, 0};
    vecs[1]  = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b101, 4'd7, 0};
    vecs[2]  = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b100, 4'd6, 0};
    vecs[3]  = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b111, 4'd5, 0};
    vecs[4]  = '{0, 1, 3'b100, 0, 3'b000, 0, 0, 1, 0, 3'b111, 4'd6, 0};
    vecs[5]  = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b100, 4'd5, 0};
    vecs[6]  = '{0, 1, 3'b110, 0, 3'b000, 0, 0, 0, 1, 3'b100, 4'd5, 0};
    vecs[7]  = '{1, 1, 3'b101, 1, 3'b011, 0, 0, 1, 0, 3'b100, 4'd6, 0};
    vecs[8]  = '{0, 0, 3'b000, 1, 3'b000, 0, 0, 0, 0, 3'b100, 4'd6, 0};
    vecs[9]  = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b000, 4'd5, 0};
    vecs[10] = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b011, 4'd4, 0};
    vecs[11] = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b100, 4'd3, 0};
    vecs[12] = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b101, 4'd2, 0};
    vecs[13] = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b110, 4'd1, 0};
    vecs[14] = '{1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b111, 4'd0, 1};
    vecs[15] = '{1, 0, 3'b000, 0, 3'b000, 0, 1, 0, 0, 3'b111, 4'd0, 1};
    vecs[16] = '{0, 1, 3'b111, 0, 3'b000, 0, 0, 1, 0, 3'b111, 4'd1, 0};

    i_rst = 1'b1; i_enter_req = 1'b0; i_exit_req = 1'b0; i_exit_token = 3'b000;
    i_pattern_load = 1'b0; i_pattern_in = 3'b000;
    @(negedge i_clk);
    doReset();

    $display("[TB] directed vector table");
    for (int v = 0; v < 17; v++) begin
      applyStimulus($sformatf("vec%0d", v), vecs[v].enter, vecs[v].exitR, vecs[v].token,
                    vecs[v].load, vecs[v].pat, vecs[v].eok, vecs[v].eerr, vecs[v].xok,
                    vecs[v].xerr, vecs[v].tok, vecs[v].free, vecs[v].full);
    end
`ifdef PARK_STATS_EN
    checkOutput("directed reject_count", o_reject_count, 8'd2);
`endif

    $display("[TB] requests while busy are ignored");
    doReset();
    i_enter_req = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_enter_req = 1'b1; i_exit_req = 1'b1; i_exit_token = 3'b000;
    i_pattern_load = 1'b1; i_pattern_in = 3'b111;
    @(posedge i_clk);
    @(negedge i_clk);
    i_enter_req = 1'b0; i_exit_req = 1'b0; i_pattern_load = 1'b0;
    checkOutput("busy-ignore RESP pulses", 8'(pulses()), 8'b1000);
    checkOutput("busy-ignore token", 8'(o_token_out), 8'd0);
    @(negedge i_clk);
    checkOutput("busy-ignore free_count", 8'(o_free_count), 8'd7);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("busy-ignore idle%0d busy", c), 8'(o_busy), 8'd0);
      checkOutput($sformatf("busy-ignore idle%0d pulses", c), 8'(pulses()), 8'd0);
      @(negedge i_clk);
    end
    applyStimulus("busy-ignore follow-up", 1, 0, 3'b000, 0, 3'b000,
                  1, 0, 0, 0, 3'b001, 4'd6, 0);

    $display("[TB] reset during ENTRY");
    doReset();
    applyStimulus("pre-abort entry", 1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b000, 4'd7, 0);
    i_enter_req = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_enter_req = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("abort pulses", 8'(pulses()), 8'd0);
    checkOutput("abort busy", 8'(o_busy), 8'd0);
    checkOutput("abort free_count", 8'(o_free_count), 8'd8);
    checkOutput("abort token_out", 8'(o_token_out), 8'd0);
    @(negedge i_clk);
    checkOutput("abort late pulses", 8'(pulses()), 8'd0);
    applyStimulus("post-abort entry", 1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0, 3'b000, 4'd7, 0);

    $display("[TB] randomized phase");
    doReset();
    for (int t = 0; t < 250; t++) randomTxn(t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_controller.md
PARKING_CONTROLLER -- requirements
Module: parking_controller

Interface
REQ-001 The module SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 enter_req  input  1  single-cycle car-entry request; sampled only in IDLE.
REQ-005 exit_req  input  1  single-cycle car-exit request; sampled only in IDLE.
REQ-006 exit_token  input  3  token presented at exit; captured with exit_req.
REQ-007 pattern_load  input  1  load pattern_in into the pattern register; honoured only in IDLE.
REQ-008 pattern_in  input  3  new cipher pattern.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 token_out  output  3  encrypted token for the allocated slot; valid with entry_ok.
REQ-011 entry_ok / entry_err  output  1 each  one-cycle entry result pulses.
REQ-012 exit_ok / exit_err  output  1 each  one-cycle exit result pulses.
REQ-013 full  output  1  all 8 slots occupied.
REQ-014 free_count  output  4  number of free slots, 0..8.

Function
REQ-015 States SHALL be IDLE, ENTRY, EXIT, RESP; IDLE->ENTRY or EXIT on an accepted request, ENTRY/EXIT->RESP, RESP->IDLE unconditionally.
REQ-016 Priority in IDLE SHALL be exit_req > enter_req > pattern_load; an unselected request in the same cycle is dropped, not queued.
REQ-017 Requests arriving while busy=1 SHALL be ignored.
REQ-018 ENTRY SHALL pick the lowest-index free slot, set its occupancy bit, and register token_out = slot XOR pattern.
REQ-019 ENTRY with full=1 SHALL leave occupancy unchanged and produce entry_err.
REQ-020 EXIT SHALL decrypt slot = exit_token XOR pattern; if that slot is occupied it SHALL be cleared with exit_ok, otherwise exit_err with no state change.
REQ-021 Result pulses SHALL be asserted for exactly the RESP cycle: the request is sampled at edge N and the result is visible in cycle N+2.
REQ-022 token_out SHALL hold its last value outside RESP; at most one result pulse SHALL be high in any cycle.
REQ-023 full and free_count SHALL be registered and SHALL reflect occupancy from the cycle after RESP.
REQ-024 pattern_load SHALL take effect from the next cycle and SHALL NOT alter occupancy, so tokens issued under an old pattern fail or misdecode by design.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, occupancy=8'h00, pattern=3'b000, token_out=0, all pulses=0, busy=0, full=0, free_count=8.
REQ-026 Reset mid-operation (ENTRY/EXIT/RESP) SHALL abort without any result pulse.

Configuration
REQ-027 With PARK_STATS_EN defined, an extra output reject_count[7:0] SHALL count entry_err+exit_err pulses, saturate at 255, and reset to 0.
REQ-028 Without PARK_STATS_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package park_pkg SHALL hold NUM_SLOTS=8, SLOT_W=3, and the state enum type.
REQ-030 Sub-module slot_finder SHALL be a combinational lowest-free-slot priority encoder: occupancy in; slot index and any_free out.

Verification
REQ-031 After reset, pattern_load with 3'b101, then enter_req -> entry_ok at N+2, token_out=3'b101 (slot 0), free_count=7.
REQ-032 Fill 8 slots, then a 9th enter_req -> entry_err, full=1, free_count=0, occupancy unchanged.
REQ-033 With pattern 3'b101 and slots 0..2 occupied, exit_req with token 3'b100 (slot 1) -> exit_ok, next entry reuses slot 1 with token 3'b100.
REQ-034 exit_req with a token decoding to a free slot -> exit_err, free_count unchanged; with PARK_STATS_EN, reject_count increments by 1.
REQ-035 enter_req and exit_req in the same IDLE cycle -> only the exit result; enter_req during busy -> no response.
REQ-036 Assert rst during ENTRY -> no entry_ok, occupancy=0, free_count=8 the next cycle.
